// File: rtl/multi_port_regfile_if.sv
// Register-file access bundle: write ports, read ports and clear-sweep control.
interface multi_port_regfile_if #(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned N_WR      = 2,
   parameter int unsigned N_RD      = 2
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [N_WR-1:0]           we;
   logic [N_WR*AW-1:0]        wr_addr;
   logic [N_WR*BUS_WIDTH-1:0] wr_data;
   logic [N_RD-1:0]           re;
   logic [N_RD*AW-1:0]        rd_addr;
   logic [N_RD*BUS_WIDTH-1:0] rd_data;
   logic                      clr;
   logic                      clr_busy;

   modport master (
      output we, wr_addr, wr_data, re, rd_addr, clr,
      input  rd_data, clr_busy
   );

   modport slave (
      input  we, wr_addr, wr_data, re, rd_addr, clr,
      output rd_data, clr_busy
   );
endinterface

// File: rtl/multi_port_regfile.sv
// Multi-port register file with optional zero register, write-to-read bypass
// and a one-entry-per-cycle clear sweep.
module multi_port_regfile #(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned N_WR      = 2,
   parameter int unsigned N_RD      = 2,
   parameter bit          ZERO_REG  = 1'b1,
   parameter bit          BYPASS    = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   multi_port_regfile_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                                state;
   logic [AW-1:0]                         ptr;
   logic                                  busy_q;
   logic [BUS_WIDTH-1:0]                  mem [DEPTH];
   logic [N_RD*BUS_WIDTH-1:0]             rd_q;

   logic [N_WR-1:0]                       wr_ok_c;
   logic [N_WR-1:0][AW-1:0]               wa_c;
   logic [N_WR-1:0][BUS_WIDTH-1:0]        wd_c;
   logic [N_RD-1:0][AW-1:0]               ra_c;
   logic [N_RD-1:0][BUS_WIDTH-1:0]        rd_next_c;

   // Entry exists (guards non-power-of-2 depths).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   // Entry 0 reads as zero and ignores writes when hardwired.
   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   // Qualify writes: only in IDLE, only to real, writable entries.
   always_comb begin
      wr_ok_c = '0;
      wa_c    = '0;
      wd_c    = '0;
      for (int i = 0; i < N_WR; i++) begin
         wa_c[i]    = bus.wr_addr[i*AW +: AW];
         wd_c[i]    = bus.wr_data[i*BUS_WIDTH +: BUS_WIDTH];
         wr_ok_c[i] = bus.we[i] && (state == IDLE) && addr_ok(wa_c[i]) &&
                      !is_zero_reg(wa_c[i]);
      end
   end

   // Read data selection; later write ports win the bypass match.
   always_comb begin
      ra_c      = '0;
      rd_next_c = '0;
      for (int j = 0; j < N_RD; j++) begin
         ra_c[j] = bus.rd_addr[j*AW +: AW];
         if (addr_ok(ra_c[j]) && !is_zero_reg(ra_c[j])) begin
            rd_next_c[j] = mem[ra_c[j]];
            if (BYPASS) begin
               for (int i = 0; i < N_WR; i++) begin
                  if (wr_ok_c[i] && (wa_c[i] == ra_c[j])) rd_next_c[j] = wd_c[i];
               end
            end
         end
      end
   end

   // Clear-sweep FSM: ascending pointer, stops at the last entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clr) begin
                  state  <= CLEAR;
                  ptr    <= '0;
                  busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (ptr == AW'(DEPTH - 1)) begin
                  state  <= IDLE;
                  ptr    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  ptr <= ptr + AW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               ptr    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage: sweep zeroes one entry per cycle, otherwise apply qualified writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (state == CLEAR) begin
         mem[ptr] <= '0;
      end else begin
         for (int i = 0; i < N_WR; i++) begin
            if (wr_ok_c[i]) mem[wa_c[i]] <= wd_c[i];
         end
      end
   end

   // Registered read ports; a disabled port holds its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else begin
         for (int j = 0; j < N_RD; j++) begin
            if (bus.re[j]) rd_q[j*BUS_WIDTH +: BUS_WIDTH] <= rd_next_c[j];
         end
      end
   end

   assign bus.rd_data  = rd_q;
   assign bus.clr_busy = busy_q;

endmodule

// File: tb/tb_multi_port_regfile.sv
// Directed bench: default instance, a no-bypass instance and a depth-6 instance.
module tb_multi_port_regfile;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   multi_port_regfile_if #(.BUS_WIDTH(8), .DEPTH(8), .N_WR(2), .N_RD(2)) bus_a ();
   multi_port_regfile_if #(.BUS_WIDTH(8), .DEPTH(8), .N_WR(2), .N_RD(2)) bus_b ();
   multi_port_regfile_if #(.BUS_WIDTH(8), .DEPTH(6), .N_WR(2), .N_RD(2)) bus_c ();

   multi_port_regfile #(.BUS_WIDTH(8), .DEPTH(8), .N_WR(2), .N_RD(2),
                        .ZERO_REG(1'b1), .BYPASS(1'b1))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

   multi_port_regfile #(.BUS_WIDTH(8), .DEPTH(8), .N_WR(2), .N_RD(2),
                        .ZERO_REG(1'b1), .BYPASS(1'b0))
      u_nb (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   multi_port_regfile #(.BUS_WIDTH(8), .DEPTH(6), .N_WR(2), .N_RD(2),
                        .ZERO_REG(1'b1), .BYPASS(1'b1))
      u_np (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

   typedef struct {
      logic [1:0]  we;
      logic [5:0]  wa;
      logic [15:0] wd;
      logic [1:0]  re;
      logic [5:0]  ra;
      logic [15:0] exp;
   } vec_t;

   vec_t vt [12];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_all();
      bus_a.we = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
      bus_a.re = '0; bus_a.rd_addr = '0; bus_a.clr = 1'b0;
      bus_b.we = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
      bus_b.re = '0; bus_b.rd_addr = '0; bus_b.clr = 1'b0;
      bus_c.we = '0; bus_c.wr_addr = '0; bus_c.wr_data = '0;
      bus_c.re = '0; bus_c.rd_addr = '0; bus_c.clr = 1'b0;
   endtask

   // Entry a gets 0x10+a (entry 0 write is dropped by the zero register).
   task automatic fill_a();
      for (int a = 0; a < 4; a++) begin
         bus_a.we      = 2'b11;
         bus_a.wr_addr = {3'(2*a+1), 3'(2*a)};
         bus_a.wr_data = {8'(8'h10 + 2*a + 1), 8'(8'h10 + 2*a)};
         step();
      end
      bus_a.we = '0;
   endtask

   task automatic read_all_zero_a(input string nm);
      for (int a = 0; a < 4; a++) begin
         bus_a.re      = 2'b11;
         bus_a.rd_addr = {3'(2*a+1), 3'(2*a)};
         step();
         chk({nm, "_p0"}, 32'(bus_a.rd_data[7:0]),  32'h0);
         chk({nm, "_p1"}, 32'(bus_a.rd_data[15:8]), 32'h0);
      end
      bus_a.re = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle_all();

      //                we     wa             wd              re     ra             exp
      vt[0]  = '{2'b01, {3'd0,3'd3}, {8'h00,8'hA5}, 2'b00, {3'd0,3'd0}, {8'h00,8'h00}};
      vt[1]  = '{2'b00, {3'd0,3'd0}, {8'h00,8'h00}, 2'b01, {3'd0,3'd3}, {8'h00,8'hA5}};
      vt[2]  = '{2'b11, {3'd5,3'd5}, {8'h22,8'h11}, 2'b10, {3'd5,3'd0}, {8'h22,8'hA5}};
      vt[3]  = '{2'b00, {3'd0,3'd0}, {8'h00,8'h00}, 2'b11, {3'd3,3'd5}, {8'hA5,8'h22}};
      vt[4]  = '{2'b01, {3'd0,3'd0}, {8'h00,8'hFF}, 2'b11, {3'd0,3'd0}, {8'h00,8'h00}};
      vt[5]  = '{2'b00, {3'd0,3'd0}, {8'h00,8'h00}, 2'b11, {3'd5,3'd3}, {8'h22,8'hA5}};
      vt[6]  = '{2'b00, {3'd0,3'd0}, {8'h00,8'h00}, 2'b01, {3'd0,3'd0}, {8'h22,8'h00}};
      vt[7]  = '{2'b11, {3'd6,3'd6}, {8'h77,8'h66}, 2'b00, {3'd0,3'd0}, {8'h22,8'h00}};
      vt[8]  = '{2'b00, {3'd0,3'd0}, {8'h00,8'h00}, 2'b10, {3'd6,3'd0}, {8'h77,8'h00}};
      vt[9]  = '{2'b01, {3'd0,3'd7}, {8'h00,8'h5A}, 2'b01, {3'd0,3'd7}, {8'h77,8'h5A}};
      vt[10] = '{2'b10, {3'd1,3'd0}, {8'h01,8'h00}, 2'b00, {3'd0,3'd0}, {8'h77,8'h5A}};
      vt[11] = '{2'b00, {3'd0,3'd0}, {8'h00,8'h00}, 2'b11, {3'd7,3'd1}, {8'h5A,8'h01}};

      // Reset values, observed without any clock edge.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rd_a",   32'(bus_a.rd_data),  32'h0);
      chk("rst_busy_a", 32'(bus_a.clr_busy), 32'h0);
      chk("rst_rd_b",   32'(bus_b.rd_data),  32'h0);
      chk("rst_rd_c",   32'(bus_c.rd_data),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: first vector lands on the first edge after reset release.
      for (int v = 0; v < 12; v++) begin
         bus_a.we      = vt[v].we;
         bus_a.wr_addr = vt[v].wa;
         bus_a.wr_data = vt[v].wd;
         bus_a.re      = vt[v].re;
         bus_a.rd_addr = vt[v].ra;
         step();
         chk($sformatf("vec%0d_p0", v), 32'(bus_a.rd_data[7:0]),  32'(vt[v].exp[7:0]));
         chk($sformatf("vec%0d_p1", v), 32'(bus_a.rd_data[15:8]), 32'(vt[v].exp[15:8]));
      end
      idle_all();

      // No-bypass instance: same-cycle read sees the old contents.
      bus_b.we = 2'b01; bus_b.wr_addr = {3'd0,3'd2}; bus_b.wr_data = {8'h00,8'h33};
      step();
      bus_b.wr_data = {8'h00,8'h44}; bus_b.re = 2'b01; bus_b.rd_addr = {3'd0,3'd2};
      step();
      chk("nobyp_same", 32'(bus_b.rd_data[7:0]), 32'h33);
      bus_b.we = '0;
      step();
      chk("nobyp_next", 32'(bus_b.rd_data[7:0]), 32'h44);
      bus_b.re = '0;

      // Depth-6 instance: addresses 6 and 7 do not exist.
      bus_c.we = 2'b01; bus_c.wr_addr = {3'd0,3'd5}; bus_c.wr_data = {8'h00,8'h55};
      step();
      bus_c.we = '0; bus_c.re = 2'b01; bus_c.rd_addr = {3'd0,3'd5};
      step();
      chk("np_rd5", 32'(bus_c.rd_data[7:0]), 32'h55);
      bus_c.we = 2'b01; bus_c.wr_addr = {3'd0,3'd6}; bus_c.wr_data = {8'h00,8'hEE};
      bus_c.rd_addr = {3'd0,3'd6};
      step();
      chk("np_byp6", 32'(bus_c.rd_data[7:0]), 32'h0);
      bus_c.we = '0; bus_c.rd_addr = {3'd0,3'd5};
      step();
      chk("np_rd5b", 32'(bus_c.rd_data[7:0]), 32'h55);
      bus_c.rd_addr = {3'd0,3'd7};
      step();
      chk("np_rd7", 32'(bus_c.rd_data[7:0]), 32'h0);
      idle_all();

      // Clear sweep with a write committed alongside the clr pulse.
      fill_a();
      bus_a.clr = 1'b1; bus_a.we = 2'b01;
      bus_a.wr_addr = {3'd0,3'd1}; bus_a.wr_data = {8'h00,8'hC1};
      step();
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("busy_k%0d", k), 32'(bus_a.clr_busy), 32'h1);
         bus_a.clr     = (k == 7);
         bus_a.we      = 2'b01;
         bus_a.wr_addr = {3'd0,3'd2};
         bus_a.wr_data = {8'h00,8'hBB};
         bus_a.re      = (k == 0 || k == 3) ? 2'b10 : (k == 7) ? 2'b01 : 2'b00;
         bus_a.rd_addr = (k == 7) ? {3'd0,3'd7} : (k == 0) ? {3'd1,3'd0} : {3'd2,3'd0};
         step();
         if (k == 0) chk("sweep_rd1_pre", 32'(bus_a.rd_data[15:8]), 32'hC1);
         if (k == 3) chk("sweep_rd2_done", 32'(bus_a.rd_data[15:8]), 32'h0);
         if (k == 7) begin
            chk("sweep_rd7_old", 32'(bus_a.rd_data[7:0]), 32'h17);
            chk("sweep_end_busy", 32'(bus_a.clr_busy), 32'h0);
         end
      end
      idle_all();
      read_all_zero_a("after_clr");

      // Reset in the middle of a sweep.
      fill_a();
      bus_a.re = 2'b11; bus_a.rd_addr = {3'd7,3'd1};
      step();
      chk("pre_rst_rd", 32'(bus_a.rd_data), 32'h1711);
      bus_a.re = '0; bus_a.clr = 1'b1;
      step();
      bus_a.clr = 1'b0;
      step(); step(); step();
      chk("mid_busy", 32'(bus_a.clr_busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus_a.clr_busy), 32'h0);
      chk("mid_rst_rd",   32'(bus_a.rd_data),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      read_all_zero_a("after_rst");
      chk("after_rst_busy", 32'(bus_a.clr_busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multi_port_regfile.md
MULTI_PORT_REGFILE -- requirements
Module: multi_port_regfile

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, data width of each entry and port.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; AW = max(1, $clog2(DEPTH)).
REQ-003 SHALL have parameter N_WR, default 2, number of write ports (1..4).
REQ-004 SHALL have parameter N_RD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter ZERO_REG, default 1, 1 = entry 0 hardwired to zero.
REQ-006 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 we  input  N_WR  per-port write enable.
REQ-010 wr_addr  input  N_WR*AW  packed write addresses, port i at [i*AW +: AW].
REQ-011 wr_data  input  N_WR*BUS_WIDTH  packed write data, port i at [i*BUS_WIDTH +: BUS_WIDTH].
REQ-012 re  input  N_RD  per-port read enable.
REQ-013 rd_addr  input  N_RD*AW  packed read addresses.
REQ-014 rd_data  output  N_RD*BUS_WIDTH  packed registered read data.
REQ-015 clr  input  1  single-cycle request to start a full-array clear sweep.
REQ-016 clr_busy  output  1  high while a clear sweep is in progress.

Function
REQ-017 Writes SHALL commit at the rising edge where we[i]=1; entry updated visible to reads issued the following cycle.
REQ-018 Reads SHALL have 1-cycle latency: rd_data port j updates at the edge where re[j]=1; re[j]=0 holds rd_data port j unchanged.
REQ-019 Write collision (two ports, same address, same cycle) SHALL resolve to the highest-indexed port's data.
REQ-020 With BYPASS=1, a read whose address matches any enabled write in the same cycle SHALL return that write's data (highest port index if several); with BYPASS=0 it SHALL return pre-write contents.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0, including under bypass.
REQ-022 Address >= DEPTH (non-power-of-2 DEPTH): write SHALL be ignored, read SHALL return 0.
REQ-023 Clear FSM states: IDLE, CLEAR; IDLE->CLEAR on clr=1; CLEAR->IDLE after sweep pointer reaches DEPTH-1.
REQ-024 In CLEAR, one entry per cycle SHALL be zeroed, pointer 0..DEPTH-1 ascending, total DEPTH cycles; clr_busy=1 exactly those DEPTH cycles, starting the cycle after clr.
REQ-025 Writes presented in the same cycle as clr (state IDLE) SHALL commit normally.
REQ-026 In CLEAR, all write enables SHALL be ignored; clr SHALL be ignored.
REQ-027 In CLEAR, reads SHALL proceed; a read of the entry being swept that cycle SHALL return its pre-clear contents; reads of already-swept entries return 0.
REQ-028 Sweep pointer width SHALL be AW; no wrap beyond DEPTH-1.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear every entry to 0, all rd_data to 0, clr_busy to 0, FSM to IDLE, sweep pointer to 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; after deassertion the block is IDLE with all entries 0.
REQ-031 First write/read/clr SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 Defaults; write port0 addr3=0xA5, next cycle re[0] addr3 -> rd_data port0 = 0xA5 one cycle later.
REQ-033 Same cycle: port0 addr5=0x11, port1 addr5=0x22, re[1] addr5 -> rd_data port1 = 0x22 (bypass); later read addr5 = 0x22.
REQ-034 BYPASS=0: entry 2=0x33; write 2=0x44 with read 2 same cycle -> 0x33; next read -> 0x44.
REQ-035 ZERO_REG=1: write addr0=0xFF, read addr0 same and next cycle -> 0x00 both.
REQ-036 Fill all entries, pulse clr -> clr_busy high 8 cycles; write during busy ignored; all reads 0 after; reading addr7 while sweep at 7 -> old value.
REQ-037 Assert rst_n=0 at sweep pointer 3 -> clr_busy=0 and rd_data=0 immediately (no clock); all entries read 0 after release.
